// File: rtl/frontend_pkg.sv
// Shared front-end definitions: default instruction width, popcount and flat-bus lane slicing.
package frontend_pkg;

  localparam int unsigned INST_W_DEF = 32;
  localparam int unsigned MAX_LANES  = 16;
  localparam int unsigned MAX_INST_W = 64;
  localparam int unsigned POP_W      = $clog2(MAX_LANES + 1);

  // Number of set bits in a lane-valid vector (zero-extended to MAX_LANES).
  function automatic logic [POP_W-1:0] popcount(input logic [MAX_LANES-1:0] v);
    logic [POP_W-1:0] n;
    n = '0;
    for (int i = 0; i < MAX_LANES; i++) begin
      n = n + POP_W'(v[i]);
    end
    return n;
  endfunction

  // Extract lane 'lane' of width 'w' from a flat bus; caller truncates to its width.
  function automatic logic [MAX_INST_W-1:0] lane_slice(
    input logic [MAX_LANES*MAX_INST_W-1:0] bus,
    input int unsigned                     lane,
    input int unsigned                     w
  );
    logic [MAX_LANES*MAX_INST_W-1:0] sh;
    sh = bus >> (lane * w);
    return sh[MAX_INST_W-1:0];
  endfunction

endpackage

// File: rtl/inst_compact.sv
// Squeezes the valid lanes of a fetch bundle into the low lanes, preserving lane order.
module inst_compact
  import frontend_pkg::*;
#(
  parameter int unsigned IN_W   = 8,
  parameter int unsigned INST_W = INST_W_DEF,
  localparam int unsigned CNT_W = $clog2(IN_W + 1)
) (
  input  logic [IN_W-1:0]        i_vld,
  input  logic [IN_W*INST_W-1:0] i_inst,
  output logic [IN_W*INST_W-1:0] o_inst,
  output logic [CNT_W-1:0]       o_n
);

  logic [INST_W-1:0] w_lane [IN_W];
  logic [INST_W-1:0] w_comp [IN_W];
  logic [CNT_W-1:0]  w_pos  [IN_W];

  for (genvar k = 0; k < IN_W; k++) begin : g_lane
    assign w_lane[k] = INST_W'(lane_slice((MAX_LANES*MAX_INST_W)'(i_inst), k, INST_W));
    assign o_inst[k*INST_W +: INST_W] = w_comp[k];
  end

  // Exclusive prefix sum: destination slot of each valid lane.
  always_comb begin
    w_pos[0] = '0;
    for (int k = 1; k < IN_W; k++) begin
      w_pos[k] = w_pos[k-1] + CNT_W'(i_vld[k-1]);
    end
  end

  // Each output slot picks the unique valid lane whose prefix sum matches it.
  always_comb begin
    for (int j = 0; j < IN_W; j++) begin
      w_comp[j] = '0;
      for (int k = 0; k < IN_W; k++) begin
        if (i_vld[k] && (w_pos[k] == CNT_W'(j))) begin
          w_comp[j] = w_lane[k];
        end
      end
    end
  end

  assign o_n = CNT_W'(popcount(MAX_LANES'(i_vld)));

endmodule

// File: rtl/inst_queue.sv
// Fetch-to-decode instruction queue: compacting multi-lane enqueue, multi-lane dequeue, flush.
module inst_queue
  import frontend_pkg::*;
#(
  parameter int unsigned IN_W   = 8,
  parameter int unsigned OUT_W  = 4,
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned INST_W = INST_W_DEF
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         flush_i,
  input  logic [IN_W-1:0]              in_vld_i,
  input  logic [IN_W*INST_W-1:0]       in_inst_i,
  output logic                         in_rdy_o,
  output logic [OUT_W-1:0]             out_vld_o,
  output logic [OUT_W*INST_W-1:0]      out_inst_o,
  input  logic [$clog2(OUT_W+1)-1:0]   deq_num_i,
  output logic [$clog2(DEPTH):0]       count_o,
  output logic                         empty_o,
  output logic                         full_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned NIN_W = $clog2(IN_W + 1);

  logic [INST_W-1:0]        r_mem [DEPTH];
  logic [PTR_W-1:0]         r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]         r_count;

  logic [PTR_W-1:0]         w_wr_ptr_nxt, w_rd_ptr_nxt;
  logic [CNT_W-1:0]         w_count_nxt;
  logic [IN_W*INST_W-1:0]   w_comp;
  logic [NIN_W-1:0]         w_n_in;
  logic                     w_rdy;
  logic                     w_enq;
  logic [CNT_W-1:0]         w_n_enq;
  logic [CNT_W-1:0]         w_n_deq;

  inst_compact #(
    .IN_W   (IN_W),
    .INST_W (INST_W)
  ) u_compact (
    .i_vld  (in_vld_i),
    .i_inst (in_inst_i),
    .o_inst (w_comp),
    .o_n    (w_n_in)
  );

  // Admission depends only on registered occupancy, never on this cycle's dequeue.
  assign w_rdy   = (CNT_W'(DEPTH) - r_count) >= CNT_W'(IN_W);
  assign w_enq   = w_rdy && (|in_vld_i) && !flush_i;
  assign w_n_enq = w_enq ? CNT_W'(w_n_in) : '0;
  assign w_n_deq = (CNT_W'(deq_num_i) > r_count) ? r_count : CNT_W'(deq_num_i);

  // Next pointer/occupancy state; flush overrides enqueue and dequeue.
  always_comb begin
    w_wr_ptr_nxt = r_wr_ptr;
    w_rd_ptr_nxt = r_rd_ptr;
    w_count_nxt  = r_count;
    if (flush_i) begin
      w_wr_ptr_nxt = '0;
      w_rd_ptr_nxt = '0;
      w_count_nxt  = '0;
    end else begin
      w_wr_ptr_nxt = r_wr_ptr + PTR_W'(w_n_enq);
      w_rd_ptr_nxt = r_rd_ptr + PTR_W'(w_n_deq);
      w_count_nxt  = r_count + w_n_enq - w_n_deq;
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= w_wr_ptr_nxt;
      r_rd_ptr <= w_rd_ptr_nxt;
      r_count  <= w_count_nxt;
    end
  end

  // Storage write: compacted lane j lands at wr_ptr + j, wrapping modulo DEPTH.
  always_ff @(posedge clock) begin
    if (w_enq) begin
      for (int j = 0; j < IN_W; j++) begin
        if (NIN_W'(j) < w_n_in) begin
          r_mem[r_wr_ptr + PTR_W'(j)] <= w_comp[j*INST_W +: INST_W];
        end
      end
    end
  end

  // Read mux: oldest OUT_W entries, zero data beyond the occupied count.
  always_comb begin
    out_vld_o  = '0;
    out_inst_o = '0;
    for (int k = 0; k < OUT_W; k++) begin
      if (CNT_W'(k) < r_count) begin
        out_vld_o[k]                   = 1'b1;
        out_inst_o[k*INST_W +: INST_W] = r_mem[r_rd_ptr + PTR_W'(k)];
      end
    end
  end

  assign in_rdy_o = w_rdy;
  assign full_o   = !w_rdy;
  assign empty_o  = (r_count == '0);
  assign count_o  = r_count;

  // Decode must not consume more than is present; hardware clamps it regardless.
  always_ff @(posedge clock) begin
    if (reset_n && !flush_i) begin
      assert (CNT_W'(deq_num_i) <= r_count)
        else $warning("inst_queue: deq_num_i %0d exceeds count %0d, clamped", deq_num_i, r_count);
    end
  end

endmodule

// File: tb/tb_inst_queue.sv
// Directed bench for inst_queue with hand-computed expected values.
module tb_inst_queue;

  localparam int unsigned IN_W   = 8;
  localparam int unsigned OUT_W  = 4;
  localparam int unsigned DEPTH  = 32;
  localparam int unsigned INST_W = 32;

  logic                       clock;
  logic                       reset_n;
  logic                       flush_i;
  logic [IN_W-1:0]            in_vld_i;
  logic [IN_W*INST_W-1:0]     in_inst_i;
  logic                       in_rdy_o;
  logic [OUT_W-1:0]           out_vld_o;
  logic [OUT_W*INST_W-1:0]    out_inst_o;
  logic [$clog2(OUT_W+1)-1:0] deq_num_i;
  logic [$clog2(DEPTH):0]     count_o;
  logic                       empty_o;
  logic                       full_o;

  int n_cmp = 0;
  int n_mis = 0;

  inst_queue #(
    .IN_W   (IN_W),
    .OUT_W  (OUT_W),
    .DEPTH  (DEPTH),
    .INST_W (INST_W)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .flush_i    (flush_i),
    .in_vld_i   (in_vld_i),
    .in_inst_i  (in_inst_i),
    .in_rdy_o   (in_rdy_o),
    .out_vld_o  (out_vld_o),
    .out_inst_o (out_inst_o),
    .deq_num_i  (deq_num_i),
    .count_o    (count_o),
    .empty_o    (empty_o),
    .full_o     (full_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  localparam logic [31:0] A = 32'hA000_0000;
  localparam logic [31:0] B = 32'hB000_0000;
  localparam logic [31:0] C = 32'hC000_0000;
  localparam logic [31:0] D = 32'hD000_0000;
  localparam logic [31:0] E = 32'hE000_0000;
  localparam logic [31:0] F = 32'hF000_0000;
  localparam logic [31:0] G = 32'h6000_0000;
  localparam logic [31:0] H = 32'h4800_0000;
  localparam logic [31:0] K = 32'h4B00_0000;
  localparam logic [31:0] W = 32'h5700_0000;
  localparam logic [31:0] X = 32'h5800_0000;
  localparam logic [31:0] Y = 32'h5900_0000;
  localparam logic [31:0] Z = 32'h5A00_0000;

  // Compare one observed value against its expected value.
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Pack four 32-bit instructions as out lanes 0..3.
  function automatic logic [127:0] ex4(input logic [31:0] l0, l1, l2, l3);
    return {l3, l2, l1, l0};
  endfunction

  // Drive one cycle of inputs; lane k carries base+k. Returns #1 after the edge.
  task automatic cyc(input logic fl, input logic [IN_W-1:0] vld,
                     input logic [31:0] base, input int deq);
    flush_i   = fl;
    in_vld_i  = vld;
    for (int k = 0; k < IN_W; k++) begin
      in_inst_i[k*INST_W +: INST_W] = base + 32'(k);
    end
    deq_num_i = 3'(deq);
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset_n   = 1'b0;
    flush_i   = 1'b0;
    in_vld_i  = '0;
    in_inst_i = '0;
    deq_num_i = '0;
    #2;
    chk("rst_count", 128'(count_o), 128'd0);
    chk("rst_empty", 128'(empty_o), 128'd1);
    chk("rst_full",  128'(full_o),  128'd0);
    chk("rst_rdy",   128'(in_rdy_o), 128'd1);
    chk("rst_vld",   128'(out_vld_o), 128'd0);
    chk("rst_inst",  128'(out_inst_o), 128'd0);
    reset_n = 1'b1;

    // Full bundle
    cyc(1'b0, 8'hFF, A, 0);
    chk("full_count", 128'(count_o), 128'd8);
    chk("full_vld",   128'(out_vld_o), 128'hF);
    chk("full_inst",  128'(out_inst_o), ex4(A, A+1, A+2, A+3));
    chk("full_empty", 128'(empty_o), 128'd0);

    // Holey bundle after flush
    cyc(1'b1, 8'h00, 32'd0, 0);
    chk("fl0_count", 128'(count_o), 128'd0);
    cyc(1'b0, 8'hA5, B, 0);
    chk("hole_count", 128'(count_o), 128'd4);
    chk("hole_inst",  128'(out_inst_o), ex4(B, B+2, B+5, B+7));

    // Fill to 25
    cyc(1'b0, 8'hFF, C, 0);
    cyc(1'b0, 8'hFF, D, 0);
    cyc(1'b0, 8'h1F, E, 0);
    chk("fill_count", 128'(count_o), 128'd25);
    chk("fill_rdy",   128'(in_rdy_o), 128'd0);
    chk("fill_full",  128'(full_o), 128'd1);
    cyc(1'b0, 8'hFF, F, 4);
    chk("rej_count", 128'(count_o), 128'd21);
    chk("rej_rdy",   128'(in_rdy_o), 128'd1);
    chk("rej_full",  128'(full_o), 128'd0);
    chk("rej_inst",  128'(out_inst_o), ex4(C, C+1, C+2, C+3));

    // Walk pointers to 28
    cyc(1'b1, 8'h00, 32'd0, 0);
    cyc(1'b0, 8'hFF, G, 0);
    cyc(1'b0, 8'hFF, G, 4);
    cyc(1'b0, 8'hFF, G, 4);
    cyc(1'b0, 8'h0F, G, 4);
    chk("walk_count", 128'(count_o), 128'd16);
    for (int i = 0; i < 4; i++) cyc(1'b0, 8'h00, 32'd0, 4);
    chk("walk_empty", 128'(empty_o), 128'd1);

    // Wrap write and read
    cyc(1'b0, 8'hFF, W, 0);
    chk("wrap_count", 128'(count_o), 128'd8);
    chk("wrap_inst0", 128'(out_inst_o), ex4(W, W+1, W+2, W+3));
    cyc(1'b0, 8'h00, 32'd0, 2);
    chk("wrap_count2", 128'(count_o), 128'd6);
    chk("wrap_inst1", 128'(out_inst_o), ex4(W+2, W+3, W+4, W+5));
    cyc(1'b0, 8'h00, 32'd0, 4);
    chk("wrap_count3", 128'(count_o), 128'd2);
    chk("wrap_vld3",   128'(out_vld_o), 128'h3);
    chk("wrap_inst3",  128'(out_inst_o), ex4(W+6, W+7, 32'd0, 32'd0));

    // Over-dequeue clamps
    cyc(1'b0, 8'h00, 32'd0, 4);
    chk("ovr_count", 128'(count_o), 128'd0);
    chk("ovr_empty", 128'(empty_o), 128'd1);
    chk("ovr_vld",   128'(out_vld_o), 128'd0);
    cyc(1'b0, 8'hFF, X, 0);
    chk("ovr_count2", 128'(count_o), 128'd8);
    chk("ovr_inst",   128'(out_inst_o), ex4(X, X+1, X+2, X+3));

    // Flush beats simultaneous enqueue and dequeue
    cyc(1'b0, 8'h0F, Y, 0);
    chk("pre_fl_count", 128'(count_o), 128'd12);
    cyc(1'b1, 8'hFF, Z, 4);
    chk("fl_count", 128'(count_o), 128'd0);
    chk("fl_empty", 128'(empty_o), 128'd1);
    chk("fl_vld",   128'(out_vld_o), 128'd0);
    chk("fl_rdy",   128'(in_rdy_o), 128'd1);
    chk("fl_inst",  128'(out_inst_o), 128'd0);
    cyc(1'b0, 8'hFF, H, 0);
    chk("postfl_count", 128'(count_o), 128'd8);
    chk("postfl_inst",  128'(out_inst_o), ex4(H, H+1, H+2, H+3));

    // Asynchronous reset mid-operation
    flush_i  = 1'b0;
    in_vld_i = '0;
    deq_num_i = '0;
    reset_n  = 1'b0;
    #1;
    chk("arst_count", 128'(count_o), 128'd0);
    chk("arst_vld",   128'(out_vld_o), 128'd0);
    chk("arst_empty", 128'(empty_o), 128'd1);
    #2;
    reset_n = 1'b1;
    cyc(1'b0, 8'hFF, K, 0);
    chk("arst_count2", 128'(count_o), 128'd8);
    chk("arst_inst",   128'(out_inst_o), ex4(K, K+1, K+2, K+3));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/inst_queue.md
# inst_queue

Parametrised decoupling queue between fetch and decode. Accepts a bundle of up to IN_W instructions per cycle with arbitrary valid lanes, compacts it, and stores it in program order in a DEPTH-entry circular buffer. Presents up to OUT_W oldest instructions per cycle to decode, which consumes 0..OUT_W of them. Supports ready/valid back-pressure and single-cycle flush.

## Interface
- IN_W, 8, fetch bundle lanes (1..16)
- OUT_W, 4, decode lanes (1..8)
- DEPTH, 32, entries; power of 2, DEPTH >= IN_W + OUT_W
- INST_W, 32, instruction width
- clock  in  1  clock, rising edge
- reset_n  in  1  reset, asynchronous, active-low
- flush_i  in  1  discard all contents; highest priority
- in_vld_i  in  IN_W  per-lane valid; holes allowed
- in_inst_i  in  IN_W*INST_W  lane k at bits [k*INST_W +: INST_W]
- in_rdy_o  out  1  bundle accepted this cycle if high
- out_vld_o  out  OUT_W  thermometer: lane k valid iff k < count
- out_inst_o  out  OUT_W*INST_W  lane k = entry[rd_ptr+k]
- deq_num_i  in  $clog2(OUT_W+1)  instructions consumed by decode this cycle
- count_o  out  $clog2(DEPTH)+1  occupied entries
- empty_o  out  1  count == 0
- full_o  out  1  free entries < IN_W (equals !in_rdy_o)

## Operation
- State: storage array, wr_ptr and rd_ptr ($clog2(DEPTH) bits, natural modulo wrap), count.
- in_rdy_o = (DEPTH - count) >= IN_W, from registered count only; it never depends on deq_num_i in the same cycle.
- Enqueue when in_rdy_o && |in_vld_i: n_in = popcount(in_vld_i). The j-th set lane, in ascending lane order, is written to entry[wr_ptr + j]. wr_ptr += n_in.
- in_vld_i == 0 while ready: no-op.
- Dequeue: n_deq = min(deq_num_i, count). rd_ptr += n_deq. deq_num_i > count is a protocol error: flagged by an assertion and clamped.
- count_next = count + n_in - n_deq. Simultaneous enqueue and dequeue are always legal.
- Flush: next cycle wr_ptr = rd_ptr = count = 0. Enqueue and dequeue in the same cycle are ignored. Stored data is not cleared.
- Output lanes with k >= count drive zero data.
- Wrap-around: lane indices are computed modulo DEPTH for both write and read. A bundle that straddles the end of the array splits across entry DEPTH-1 and entry 0.

## Timing
- Reset values: count_o = 0, empty_o = 1, full_o = 0, in_rdy_o = 1, out_vld_o = 0, out_inst_o = 0. Both pointers = 0.
- Latency: an instruction enqueued at edge N is visible on out_* after edge N. There is no same-cycle bypass.
- out_* are combinational from registered state only, with no input-to-output paths, except that the assertion checks deq_num_i.
- Flush asserted in cycle N: in_rdy_o = 1 and empty_o = 1 from cycle N+1.
- Reset asserted mid-operation: all state returns to reset values asynchronously. After release, the first bundle is accepted on the first edge.

## Structure
- Shared package frontend_pkg holds:
  - INST_W default
  - popcount function
  - lane-slice helper for flat buses
- Sub-module inst_compact (combinational): computes per-lane prefix sums of in_vld_i and produces the compacted lane array plus n_in. It is instantiated once.
- Top level holds pointers, count, storage, and the output read mux.

## Test plan
- Reset, then bundle in_vld_i = 8'hFF carrying I0..I7 with deq_num_i = 0 → count_o = 8 next cycle; out lanes = I0..I3; out_vld_o = 4'hF.
- Bundle in_vld_i = 8'b1010_0101 (I0, I2, I5, I7) → stored contiguously; out lanes = I0, I2, I5, I7; count_o = 4.
- Fill to 25 with deq 0 → in_rdy_o = 0 and full_o = 1. Then enqueue 8 and dequeue 4 in the same cycle → bundle rejected; count_o = 21; in_rdy_o = 1 next cycle.
- Wrap: set rd_ptr = wr_ptr = 28 via traffic, then enqueue 8 → entries 28..31, 0..3. Output order is preserved across the wrap.
- Flush together with an enqueue of 8 and deq_num_i = 4, count 12 → next cycle count_o = 0, empty_o = 1, out_vld_o = 0.
- deq_num_i = 4 with count 2 → assertion fires; count_o = 0; pointers stay consistent.
